// File: rtl/qam_demap_sequencer.sv
// qam_demap_sequencer: strobe sequencer for the 16QAM demapper datapath (calibration, latch, shift burst).
// Define QAM_SEQ_PEND_EN to add a one-deep pending-symbol slot.
module qam_demap_sequencer #(
  parameter int BITS_PER_SYM = 4,
  parameter int CAL_SETTLE   = 8
) (
  input  logic i_dclk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_cal,
  input  logic i_sym_valid,
  input  logic i_ovr_clr,
  output logic o_latch_offset,
  output logic o_latch_reg,
  output logic o_shift,
  output logic o_busy,
  output logic o_cal_done,
  output logic o_overrun
);
  localparam int MAXV = BITS_PER_SYM > CAL_SETTLE ? BITS_PER_SYM : CAL_SETTLE;
  localparam int CW   = MAXV > 1 ? $clog2(MAXV) : 1;
  typedef enum logic [2:0] {IDLE, CAL_WAIT, CAL_LATCH, LATCH, SHIFT} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_cal_done, r_overrun;
  logic          w_sv, w_last, w_slot, w_slot_ovr, w_ovr_set, w_pending;
  assign w_sv   = i_sym_valid & i_en;
  assign w_last = (r_state == SHIFT) && (r_cnt == '0);
  // a symbol arriving while one is still being latched or shifted out
  assign w_slot = w_sv & ((r_state == LATCH) | ((r_state == SHIFT) & ~w_last));
`ifdef QAM_SEQ_PEND_EN
  logic r_pending;
  assign w_pending  = r_pending;
  assign w_slot_ovr = w_slot & r_pending;
  always_ff @(posedge i_dclk or posedge i_rst)
    if (i_rst) r_pending <= 1'b0;
    else       r_pending <= w_last ? 1'b0 : (r_pending | w_slot);
`else
  assign w_pending  = 1'b0;
  assign w_slot_ovr = w_slot;
`endif
  always_comb begin
    w_next    = r_state;
    w_cnt     = r_cnt;
    w_ovr_set = w_slot_ovr;
    case (r_state)
      IDLE: begin
        w_next    = i_cal ? CAL_WAIT : (w_sv ? LATCH : IDLE);
        w_cnt     = i_cal ? CW'(CAL_SETTLE - 1) : r_cnt;
        w_ovr_set = i_cal & w_sv;
      end
      CAL_WAIT: begin
        w_cnt     = r_cnt - 1'b1;
        w_next    = (r_cnt == '0) ? CAL_LATCH : CAL_WAIT;
        w_ovr_set = w_sv;
      end
      CAL_LATCH: begin
        w_next    = IDLE;
        w_ovr_set = w_sv;
      end
      LATCH: begin
        w_next = SHIFT;
        w_cnt  = CW'(BITS_PER_SYM - 1);
      end
      default: begin
        w_cnt  = r_cnt - 1'b1;
        w_next = !w_last ? SHIFT : ((i_en && (w_pending || w_sv)) ? LATCH : IDLE);
      end
    endcase
  end
  always_ff @(posedge i_dclk or posedge i_rst)
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cal_done <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_cal_done <= r_cal_done | (r_state == CAL_LATCH);
      r_overrun  <= w_ovr_set | (r_overrun & ~i_ovr_clr);
    end
  assign o_latch_offset = r_state == CAL_LATCH;
  assign o_latch_reg    = r_state == LATCH;
  assign o_shift        = r_state == SHIFT;
  assign o_busy         = r_state != IDLE;
  assign o_cal_done     = r_cal_done;
  assign o_overrun      = r_overrun;
endmodule

// File: tb/tb_qam_demap_sequencer.sv
// tb_qam_demap_sequencer: directed and random checks of the sequencer against a timeline model.
module tb_qam_demap_sequencer;
  localparam int B = 4, C = 8, N = 4096;
`ifdef QAM_SEQ_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cal = 1'b0, sv = 1'b0, clr = 1'b0;
  logic o_latch_offset, o_latch_reg, o_shift, o_busy, o_cal_done, o_overrun;
  always #5 clk = ~clk;
  qam_demap_sequencer #(.BITS_PER_SYM(B), .CAL_SETTLE(C)) dut (
    .i_dclk(clk), .i_rst(rst), .i_en(en), .i_cal(cal), .i_sym_valid(sv), .i_ovr_clr(clr),
    .o_latch_offset(o_latch_offset), .o_latch_reg(o_latch_reg), .o_shift(o_shift),
    .o_busy(o_busy), .o_cal_done(o_cal_done), .o_overrun(o_overrun));
  int n_eval = 0, n_fail = 0, t = 0, lr_cnt = 0, sh_cnt = 0;
  // expected per-cycle strobes laid out on a timeline as activities are accepted
  bit e_lr[N], e_sh[N], e_lo[N], e_busy[N];
  int act_end = -1, cd_from = 1 << 30;
  bit act_cal = 1'b0, pend = 1'b0, ovr = 1'b0;
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %b expected %b", tag, t, obs, exp);
    end
  endtask
  task automatic chk_n(input string tag, input int obs, input int exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic void sched_sym(input int s);
    e_lr[s] = 1'b1;
    for (int i = 0; i <= B; i++) e_busy[s+i] = 1'b1;
    for (int i = 1; i <= B; i++) e_sh[s+i] = 1'b1;
    act_end = s + B;
    act_cal = 1'b0;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      e_lr[i] = 1'b0; e_sh[i] = 1'b0; e_lo[i] = 1'b0; e_busy[i] = 1'b0;
    end
    act_end = -1; cd_from = 1 << 30; act_cal = 1'b0; pend = 1'b0; ovr = 1'b0;
  endfunction
  function automatic void model_edge(input bit e, input bit c, input bit v, input bit k);
    bit vs, set;
    vs = v & e;
    set = 1'b0;
    if (t > act_end) begin
      if (c) begin
        for (int i = 1; i <= C + 1; i++) e_busy[t+i] = 1'b1;
        e_lo[t+C+1] = 1'b1;
        act_end = t + C + 1;
        act_cal = 1'b1;
        if (t + C + 2 < cd_from) cd_from = t + C + 2;
        set = vs;
      end else if (vs) sched_sym(t + 1);
    end else if (act_cal) set = vs;
    else if (t == act_end) begin
      if (e && (pend || vs)) sched_sym(t + 1);
      pend = 1'b0;
    end else if (vs) begin
      if (PEND && !pend) pend = 1'b1;
      else set = 1'b1;
    end
    ovr = set ? 1'b1 : (k ? 1'b0 : ovr);
  endfunction
  task automatic step(input bit e, input bit c, input bit v, input bit k);
    en = e; cal = c; sv = v; clr = k;
    @(posedge clk);
    model_edge(e, c, v, k);
    t++;
    #1;
    chk("latch_reg", o_latch_reg, e_lr[t]);
    chk("shift", o_shift, e_sh[t]);
    chk("latch_offset", o_latch_offset, e_lo[t]);
    chk("busy", o_busy, e_busy[t]);
    chk("cal_done", o_cal_done, t >= cd_from);
    chk("overrun", o_overrun, ovr);
    lr_cnt += int'(o_latch_reg);
    sh_cnt += int'(o_shift);
  endtask
  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    en = 1'b0; cal = 1'b0; sv = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_latch_offset", o_latch_offset, 1'b0);
    chk("rst_latch_reg", o_latch_reg, 1'b0);
    chk("rst_shift", o_shift, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cal_done", o_cal_done, 1'b0);
    chk("rst_overrun", o_overrun, 1'b0);
    model_reset();
    t = 0; lr_cnt = 0; sh_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    model_reset();
    #3;
    chk("por_busy", o_busy, 1'b0);
    chk("por_cal_done", o_cal_done, 1'b0);
    chk("por_overrun", o_overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // single symbol
    step(1, 0, 1, 0);
    idle(6, 1);
    chk_n("single_latch_count", lr_cnt, 1);
    chk_n("single_shift_count", sh_cnt, B);
    // calibration with a symbol dropped mid-settle
    do_reset();
    step(1, 1, 0, 0);
    idle(3, 1);
    step(1, 0, 1, 0);
    idle(7, 1);
    chk_n("cal_no_latch_reg", lr_cnt, 0);
    chk("cal_done_after", o_cal_done, 1'b1);
    chk("cal_overrun", o_overrun, 1'b1);
    // back-to-back at the maximum rate
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, (i % 5) == 0, 0);
    idle(3, 1);
    chk_n("b2b_latch_count", lr_cnt, 4);
    chk_n("b2b_shift_count", sh_cnt, 16);
    chk("b2b_overrun", o_overrun, 1'b0);
    // pending / overrun then clear
    do_reset();
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    idle(9, 1);
    chk_n("pend_latch_count", lr_cnt, PEND ? 2 : 1);
    chk("pend_overrun", o_overrun, 1'b1);
    step(1, 0, 0, 1);
    chk("ovr_clr", o_overrun, 1'b0);
    // en low ignores symbols; dropping en discards a pending symbol
    do_reset();
    step(0, 0, 1, 0);
    idle(3, 0);
    chk_n("en0_no_latch", lr_cnt, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    idle(6, 0);
    chk_n("en_drop_latch_count", lr_cnt, 1);
    chk_n("en_drop_shift_count", sh_cnt, B);
    // reset in the middle of a shift burst after a calibration
    do_reset();
    step(1, 1, 0, 0);
    idle(C + 2, 1);
    step(1, 0, 1, 0);
    idle(2, 1);
    chk("pre_rst_shift", o_shift, 1'b1);
    do_reset();
    step(1, 0, 1, 0);
    idle(6, 1);
    chk_n("post_rst_latch_count", lr_cnt, 1);
    // randomized traffic in segments
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int i = 0; i < 600; i++)
        step($urandom_range(7) != 0, $urandom_range(39) == 0,
             $urandom_range(2) == 0, $urandom_range(9) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
